// File: rtl/gray_sync_decoder.sv
// Gray-code synchronizer and decoder.
// A Gray count from an unrelated clock domain passes through a flop chain.
// Each accepted change is then decoded to binary. The block reports the
// modular step from the previous accepted value, and it flags any change
// that moves more than one Gray bit at once.
module gray_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] delta,
  output logic             bin_valid,
  output logic             step_err,
  output logic             busy
);

  // The INIT counter only needs to reach SYNC_STAGES, which is its final value.
  localparam int             CNT_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_STAGES);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] init_cnt;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_gray;
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] sync_bin;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] step_delta;
  logic             changed;
  logic             multi_flip;

  // Decode Gray to binary. Each binary bit is the running XOR of the Gray bits
  // from the MSB down to that bit.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // A legal Gray step flips exactly one bit. This function reports whether
  // more than one bit differs.
  function automatic logic more_than_one(input logic [WIDTH-1:0] diff);
    int cnt;
    cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (diff[i]) cnt++;
    end
    return (cnt > 1);
  endfunction

  // Synchronizer chain: stage 0 samples the asynchronous input directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_gray = sync_q[SYNC_STAGES-1];

  // Derive the decoded values, the modular step and the step legality
  // from the synchronized code and the last accepted code.
  always_comb begin
    sync_bin   = gray_to_bin(sync_gray);
    prev_bin   = gray_to_bin(prev_gray);
    step_delta = sync_bin - prev_bin;
    changed    = (sync_gray != prev_gray);
    multi_flip = more_than_one(sync_gray ^ prev_gray);
  end

  // Control FSM. INIT waits until the synchronizer holds real data and then
  // seeds the reference code. RUN accepts each change and reports it.
  // Reset overrides everything. A new step error wins over err_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      init_cnt  <= '0;
      prev_gray <= '0;
      bin_out   <= '0;
      delta     <= '0;
      bin_valid <= 1'b0;
      step_err  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      bin_valid <= 1'b0;
      case (state)
        INIT: begin
          busy <= 1'b1;
          if (init_cnt == CNT_LAST) begin
            prev_gray <= sync_gray;
            bin_out   <= sync_bin;
            delta     <= '0;
            init_cnt  <= '0;
            busy      <= 1'b0;
            state     <= RUN;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        RUN: begin
          busy <= 1'b0;
          if (changed) begin
            bin_out   <= sync_bin;
            delta     <= step_delta;
            bin_valid <= 1'b1;
            prev_gray <= sync_gray;
          end
        end
        default: begin
          state <= INIT;
          busy  <= 1'b1;
        end
      endcase

      if ((state == RUN) && changed && multi_flip) begin
        step_err <= 1'b1;
      end else if (err_clr) begin
        step_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Scoreboard bench for gray_sync_decoder (WIDTH=4, SYNC_STAGES=2).
// The stimulus pushes the expected result of every accepted code change.
// A monitor pops and compares whenever bin_valid pulses.
module tb_gray_sync_decoder;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] gray_in;
  logic             err_clr;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] delta;
  logic             bin_valid;
  logic             step_err;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] dlt;
    logic             err;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  int               checks;
  int               failures;
  int               cycle;
  int               gray_of [16];
  int               inv_tab [16];
  logic [WIDTH-1:0] m_gray;
  logic             m_err;

  gray_sync_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gray_in  (gray_in),
    .err_clr  (err_clr),
    .bin_out  (bin_out),
    .delta    (delta),
    .bin_valid(bin_valid),
    .step_err (step_err),
    .busy     (busy)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so the monitor can check latency.
  always @(posedge clk) cycle <= cycle + 1;

  // Safety net so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Model: accept a new code and queue the response the DUT must give.
  task automatic driveCode(input logic [WIDTH-1:0] g);
    exp_t e;
    int   nb;
    int   ob;
    gray_in = g;
    if (g != m_gray) begin
      nb    = inv_tab[g];
      ob    = inv_tab[m_gray];
      m_err = m_err | ($countones(g ^ m_gray) > 1);
      e.bin = 4'(nb);
      e.dlt = 4'((nb - ob + 16) % 16);
      e.err = m_err;
      e.cyc = cycle + SYNC + 1;
      sb.push_back(e);
      m_gray = g;
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] g, input int hold);
    @(negedge clk);
    driveCode(g);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic stepBy(input int dir, input int hold);
    int nb;
    nb = (inv_tab[m_gray] + dir + 16) % 16;
    applyStimulus(4'(gray_of[nb]), hold);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_wait actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clearErr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err   = 1'b0;
    checkOutput("err_clr", step_err, 0);
  endtask

  // Pulse reset for one edge, then check the zero state and the busy window.
  task automatic doReset();
    int nbusy;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_bin_out", bin_out, 0);
    checkOutput("rst_delta", delta, 0);
    checkOutput("rst_valid", bin_valid, 0);
    checkOutput("rst_step_err", step_err, 0);
    checkOutput("rst_busy", busy, 1);
    sb.delete();
    rst_n = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      if (!busy) break;
      nbusy++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", nbusy, SYNC + 1);
    m_gray = gray_in;
    m_err  = 1'b0;
    checkOutput("init_bin_out", bin_out, inv_tab[gray_in]);
    checkOutput("init_delta", delta, 0);
    checkOutput("init_step_err", step_err, 0);
  endtask

  // Monitor: compare every bin_valid pulse against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    checkOutput("busy_and_valid", busy & bin_valid, 0);
    if (bin_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid actual=bin_%0h required=no_pulse", bin_out);
      end else begin
        e = sb.pop_front();
        checkOutput("bin_out", bin_out, e.bin);
        checkOutput("delta", delta, e.dlt);
        checkOutput("step_err", step_err, e.err);
        checkOutput("latency", cycle, e.cyc);
      end
    end
  end

  initial begin
    int r;
    int nb;
    checks   = 0;
    failures = 0;
    cycle    = 0;
    for (int b = 0; b < 16; b++) begin
      gray_of[b] = b ^ (b >> 1);
      inv_tab[gray_of[b]] = b;
    end
    rst_n   = 1'b0;
    gray_in = '0;
    err_clr = 1'b0;
    m_gray  = '0;
    m_err   = 1'b0;

    // Reset release with gray 0000.
    doReset();

    // Short ascending run 0001, 0011, 0010.
    applyStimulus(4'b0001, 4);
    applyStimulus(4'b0011, 4);
    applyStimulus(4'b0010, 4);
    waitIdle();
    checkOutput("run3_bin", bin_out, 4'd3);

    // Ascending walk through the top code 1000 and wrap to 0000.
    for (int i = 0; i < 13; i++) stepBy(1, 3);
    waitIdle();
    checkOutput("wrap_bin", bin_out, 4'd0);
    checkOutput("wrap_delta", delta, 4'd1);
    checkOutput("wrap_err", step_err, 0);

    // Up to 0111, then one step back to 0110.
    for (int i = 0; i < 5; i++) stepBy(1, 3);
    applyStimulus(4'b0110, 4);
    waitIdle();
    checkOutput("down_bin", bin_out, 4'd4);
    checkOutput("down_delta", delta, 4'hF);
    checkOutput("down_err", step_err, 0);

    // Two-bit jump 0000 -> 0011, sticky error, clear, then clear racing a set.
    for (int i = 0; i < 4; i++) stepBy(-1, 3);
    applyStimulus(4'b0011, 4);
    waitIdle();
    checkOutput("jump_bin", bin_out, 4'd2);
    checkOutput("jump_delta", delta, 4'd2);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", step_err, 1);
    clearErr();
    @(negedge clk);
    err_clr = 1'b1;
    driveCode(4'b0000);
    repeat (3) @(negedge clk);
    err_clr = 1'b0;
    waitIdle();
    checkOutput("set_wins", step_err, 1);
    clearErr();

    // Reset lands on the edge where a change is due out.
    @(negedge clk);
    gray_in = 4'(gray_of[(inv_tab[m_gray] + 1) % 16]);
    repeat (2) @(negedge clk);
    doReset();

    // Random walk with occasional multi-bit jumps.
    for (int it = 0; it < 160; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        stepBy(1, $urandom_range(2, 5));
      end else if (r < 8) begin
        stepBy(-1, $urandom_range(2, 5));
      end else begin
        nb = $urandom_range(0, 15);
        applyStimulus(4'(gray_of[nb]), $urandom_range(2, 5));
      end
      if (it % 40 == 39) begin
        waitIdle();
        checkOutput("rand_err_state", step_err, m_err);
        if (m_err) clearErr();
      end
    end
    waitIdle();
    checkOutput("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_sync_decoder.md
GRAY_SYNC_DECODER -- requirements
Module: gray_sync_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the code width in bits (minimum 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth (minimum 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: synchronous and active-low.
REQ-005 SHALL have port gray_in, input, WIDTH, a Gray-coded count from an unrelated source, asynchronous to clk.
REQ-006 SHALL have port err_clr, input, 1, which clears the sticky step_err.
REQ-007 SHALL have port bin_out, output, WIDTH, the binary value of the last accepted Gray code (registered).
REQ-008 SHALL have port delta, output, WIDTH, the modular difference from the previous accepted binary value (registered).
REQ-009 SHALL have port bin_valid, output, 1, a one-cycle pulse when bin_out and delta update.
REQ-010 SHALL have port step_err, output, 1, sticky: set when one accepted change flips more than one Gray bit.
REQ-011 SHALL have port busy, output, 1, which is high while in state INIT.

Function
REQ-012 SHALL pass gray_in through a chain of SYNC_STAGES flops; stage 1 samples gray_in directly, and the last stage is sync_gray.
REQ-013 SHALL decode Gray to binary as follows: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i from WIDTH-2 down to 0.
REQ-014 SHALL use FSM states INIT and RUN, and SHALL enter INIT on reset.
REQ-015 In INIT, a counter SHALL count SYNC_STAGES+1 cycles; on the final cycle the block SHALL load prev_gray with sync_gray and load bin_out with decode(sync_gray), hold delta at 0, issue no bin_valid, and go to RUN.
REQ-016 In RUN, when sync_gray != prev_gray, then on the next edge: bin_out = decode(sync_gray); delta = decode(sync_gray) - decode(prev_gray) mod 2^WIDTH; bin_valid = 1; prev_gray = sync_gray.
REQ-017 In RUN, when sync_gray == prev_gray, the block SHALL set bin_valid = 0 and hold bin_out, delta and prev_gray.
REQ-018 Latency: a gray_in value that is stable before edge k SHALL appear on bin_out with bin_valid at edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 edges inclusive.
REQ-019 Wrap-around: the step from WIDTH-bit max to 0 SHALL be a legal single-bit step; for WIDTH=4, gray 1000 to 0000 SHALL give delta = 0001 and no error.
REQ-020 Step check: if popcount(sync_gray XOR prev_gray) > 1 on an accepted change, step_err SHALL set on the same edge as bin_valid; bin_out and delta SHALL still update per REQ-016.
REQ-021 step_err SHALL stay set until err_clr is sampled high; if err_clr and a new error occur on the same edge, set SHALL win.
REQ-022 Backwards single-bit steps (count down) SHALL be legal; delta SHALL be the modular difference, e.g. bin 5 to 4 gives delta = 1111 for WIDTH=4.
REQ-023 bin_valid SHALL never be asserted in INIT, and err_clr SHALL be honoured in either state.

Reset
REQ-024 When rst_n is sampled low, the block SHALL clear every sync stage, prev_gray, bin_out, delta, bin_valid and step_err to 0, clear the INIT counter to 0, and enter INIT (busy = 1).
REQ-025 Reset asserted mid-operation SHALL take priority over all other updates on that edge, including a pending bin_valid and the setting of step_err.
REQ-026 After rst_n deasserts, busy SHALL stay high for exactly SYNC_STAGES+1 cycles; busy and bin_valid SHALL never be high on the same cycle.

Verification (WIDTH=4, SYNC_STAGES=2)
REQ-027 Reset release with gray_in = 0000 -> busy high for 3 cycles, then bin_out = 0000, delta = 0000, bin_valid never pulses, step_err = 0.
REQ-028 In RUN, gray_in 0000 -> 0001 -> 0011 -> 0010, each held 4 cycles -> bin_valid pulses 3 times, 3 edges after each change; bin_out = 0001, 0010, 0011; delta = 0001 each time.
REQ-029 Full 16-code ascending walk ending at 1000, then 0000 -> last pulse gives bin_out = 0000, delta = 0001, step_err = 0.
REQ-030 Jump 0000 -> 0011 -> bin_out = 0010, delta = 0010, step_err = 1 and held; err_clr for one cycle -> step_err = 0; err_clr held on the same edge as another 2-bit jump -> step_err stays 1.
REQ-031 Reset pulsed on the cycle a change is due out -> no bin_valid; all outputs 0; busy = 1 for 3 cycles after release.
REQ-032 Descending step 0111 -> 0110 (bin 5 -> 4) -> bin_out = 0100, delta = 1111, step_err unchanged.
